// File: rtl/pulse_narrow_pkg.sv
// Shared types and constants for the pulse_narrow digit-line decoder.
// Holds the FSM state enum, error codes and default pulse-width limits.
package pulse_narrow_pkg;

   localparam int DATA_W        = 10;
   localparam int IDX_W         = 4;
   localparam int CNT_W         = 3;
   localparam int DEF_MIN_WIDTH = 2;
   localparam int DEF_MAX_WIDTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_e;

   typedef logic [1:0] err_type_t;

   localparam err_type_t ERR_NONE  = 2'b00;
   localparam err_type_t ERR_CODE  = 2'b01;
   localparam err_type_t ERR_SHORT = 2'b10;
   localparam err_type_t ERR_LONG  = 2'b11;

endpackage

// File: rtl/pulse_narrow_onehot_index.sv
// Combinational classifier for the 10-bit digit line: bit index of the
// highest set bit plus zero / one-hot / multi-hot flags.
module onehot_index
   import pulse_narrow_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [IDX_W-1:0]  idx_o,
   output logic              is_zero_o,
   output logic              is_onehot_o,
   output logic              is_multi_o
);

   logic single_bit;

   always_comb begin
      idx_o = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (data_i[i]) begin
            idx_o = IDX_W'(i);
         end
      end
   end

   // Clearing the lowest set bit leaves zero only for a power of two.
   assign single_bit  = ((data_i & (data_i - DATA_W'(1))) == '0);
   assign is_zero_o   = (data_i == '0);
   assign is_onehot_o = !is_zero_o && single_bit;
   assign is_multi_o  = !is_zero_o && !single_bit;

endmodule

// File: rtl/pulse_narrow.sv
// Decodes stretched one-hot pulses on a 10-bit digit line into digits,
// rejecting pulses that are too short, too long, multi-hot or change code.
module pulse_narrow
   import pulse_narrow_pkg::*;
#(
   parameter int MIN_WIDTH = DEF_MIN_WIDTH,
   parameter int MAX_WIDTH = DEF_MAX_WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] data_in,
   output logic [IDX_W-1:0]  digit_out,
   output logic              digit_valid,
   output logic              err,
   output logic [1:0]        err_type,
   output logic              busy,
   output state_e            dbg_state
);

   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(MAX_WIDTH + 1);

   logic [DATA_W-1:0] data_q, data_d;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  code_q, code_d;
   logic [IDX_W-1:0]  digit_q, digit_d;
   logic              digit_valid_q, digit_valid_d;
   logic              err_q, err_d;
   err_type_t         err_type_q, err_type_d;
   logic              busy_q, busy_d;

   logic [IDX_W-1:0]  idx;
   logic              is_zero;
   logic              is_onehot;
   logic              is_multi;
   logic              same_code;

   onehot_index u_onehot_index (
      .data_i      (data_q),
      .idx_o       (idx),
      .is_zero_o   (is_zero),
      .is_onehot_o (is_onehot),
      .is_multi_o  (is_multi)
   );

   assign data_d    = enable ? data_in : '0;
   assign same_code = is_onehot && (idx == code_q);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      code_d        = code_q;
      digit_d       = digit_q;
      digit_valid_d = 1'b0;
      err_d         = 1'b0;
      err_type_d    = err_type_q;

      case (state_q)
         ST_IDLE: begin
            if (is_onehot) begin
               code_d  = idx;
               cnt_d   = CNT_W'(1);
               state_d = ST_ACTIVE;
            end else if (is_multi) begin
               err_d      = 1'b1;
               err_type_d = ERR_CODE;
               state_d    = ST_DRAIN;
            end
         end

         ST_ACTIVE: begin
            if (is_zero) begin
               // End of pulse: cnt holds the number of cycles the code was seen.
               state_d = ST_IDLE;
               if (cnt_q < MIN_CNT) begin
                  err_d      = 1'b1;
                  err_type_d = ERR_SHORT;
               end else if (cnt_q > MAX_CNT) begin
                  err_d      = 1'b1;
                  err_type_d = ERR_LONG;
               end else begin
                  digit_valid_d = 1'b1;
                  digit_d       = code_q;
               end
            end else if (same_code) begin
               if (cnt_q < SAT_CNT) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               err_d      = 1'b1;
               err_type_d = ERR_CODE;
               state_d    = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (is_zero) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q        <= '0;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         code_q        <= '0;
         digit_q       <= '0;
         digit_valid_q <= 1'b0;
         err_q         <= 1'b0;
         err_type_q    <= ERR_NONE;
         busy_q        <= 1'b0;
      end else begin
         data_q        <= data_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         code_q        <= code_d;
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         err_q         <= err_d;
         err_type_q    <= err_type_d;
         busy_q        <= busy_d;
      end
   end

   assign digit_out   = digit_q;
   assign digit_valid = digit_valid_q;
   assign err         = err_q;
   assign err_type    = err_type_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_narrow.sv
// Bench for pulse_narrow: directed vector table, reset sequences, and
// randomized pulses checked against a segment-based reference model.
module tb_pulse_narrow;
   import pulse_narrow_pkg::*;

   localparam int MIN_W = 2;
   localparam int MAX_W = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [9:0] data_in;
   logic [3:0] digit_out;
   logic       digit_valid;
   logic       err;
   logic [1:0] err_type;
   logic       busy;
   state_e     dbg_state;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   pulse_narrow #(.MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .data_in     (data_in),
      .digit_out   (digit_out),
      .digit_valid (digit_valid),
      .err         (err),
      .err_type    (err_type),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the current nonzero segment of the sampled line.
   int         seg_len;
   logic [9:0] seg_first;
   bit         seg_bad;
   logic [9:0] prev_s;
   logic       exp_valid, exp_err, exp_busy;
   logic [1:0] exp_type;
   logic [3:0] exp_digit;

   typedef struct {
      logic [9:0] data;
      logic       en;
      logic       valid;
      logic       err;
      logic [1:0] etype;
      logic [3:0] digit;
      logic       busy;
   } vec_t;

   vec_t vecs[41];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
   endtask

   function automatic int bit_pos(input logic [9:0] v);
      for (int i = 0; i < 10; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      seg_len   = 0;
      seg_bad   = 0;
      seg_first = '0;
      prev_s    = '0;
      exp_valid = 0;
      exp_err   = 0;
      exp_busy  = 0;
      exp_type  = 2'b00;
      exp_digit = 4'd0;
   endtask

   task automatic model_process(input logic [9:0] v);
      exp_valid = 0;
      exp_err   = 0;
      if (v == '0) begin
         if (seg_len > 0 && !seg_bad) begin
            if (seg_len < MIN_W) begin
               exp_err = 1; exp_type = 2'b10;
            end else if (seg_len > MAX_W) begin
               exp_err = 1; exp_type = 2'b11;
            end else begin
               exp_valid = 1; exp_digit = 4'(bit_pos(seg_first));
            end
         end
         seg_len = 0;
         seg_bad = 0;
      end else begin
         if (seg_len == 0) seg_first = v;
         if (!seg_bad && ($countones(v) != 1 || v != seg_first)) begin
            exp_err  = 1;
            exp_type = 2'b01;
            seg_bad  = 1;
         end
         seg_len++;
      end
      exp_busy = (v != '0);
   endtask

   // Entered and left just after a falling edge.
   task automatic step(input logic [9:0] d, input logic en);
      data_in = d;
      enable  = en;
      @(posedge clk);
      model_process(prev_s);
      prev_s = en ? d : '0;
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".digit_valid"}, int'(digit_valid), int'(exp_valid));
      check({tag, ".err"}, int'(err), int'(exp_err));
      check({tag, ".err_type"}, int'(err_type), int'(exp_type));
      check({tag, ".digit_out"}, int'(digit_out), int'(exp_digit));
      check({tag, ".busy"}, int'(busy), int'(exp_busy));
      check({tag, ".valid_and_err"}, int'(digit_valid & err), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".digit_valid"}, int'(digit_valid), 0);
      check({tag, ".err"}, int'(err), 0);
      check({tag, ".err_type"}, int'(err_type), 0);
      check({tag, ".digit_out"}, int'(digit_out), 0);
      check({tag, ".busy"}, int'(busy), 0);
      check({tag, ".state"}, int'(dbg_state), int'(ST_IDLE));
   endtask

   // Entered just after a falling edge; holds reset across one rising edge.
   task automatic do_reset(input logic [9:0] d, input string tag);
      data_in = d;
      rst_n   = 1'b0;
      #1;
      check_zero({tag, ".async"});
      model_reset();
      @(posedge clk);
      @(negedge clk);
      check_zero({tag, ".held"});
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [9:0] d, input logic en, input logic v,
                               input logic e, input logic [1:0] t, input logic [3:0] g,
                               input logic b);
      vec_t r;
      r.data = d; r.en = en; r.valid = v; r.err = e; r.etype = t; r.digit = g; r.busy = b;
      return r;
   endfunction

   initial begin
      // 3-wide digit 3, then 1-wide (short), 5-wide (long), changed code,
      // digit 4, enable-gated line, enable drop mid-pulse, no-gap code change.
      vecs[0]  = mk(10'h008, 1, 0, 0, 2'd0, 4'd0, 0);
      vecs[1]  = mk(10'h008, 1, 0, 0, 2'd0, 4'd0, 1);
      vecs[2]  = mk(10'h008, 1, 0, 0, 2'd0, 4'd0, 1);
      vecs[3]  = mk(10'h000, 1, 0, 0, 2'd0, 4'd0, 1);
      vecs[4]  = mk(10'h000, 1, 1, 0, 2'd0, 4'd3, 0);
      vecs[5]  = mk(10'h000, 1, 0, 0, 2'd0, 4'd3, 0);
      vecs[6]  = mk(10'h200, 1, 0, 0, 2'd0, 4'd3, 0);
      vecs[7]  = mk(10'h000, 1, 0, 0, 2'd0, 4'd3, 1);
      vecs[8]  = mk(10'h000, 1, 0, 1, 2'd2, 4'd3, 0);
      vecs[9]  = mk(10'h000, 1, 0, 0, 2'd2, 4'd3, 0);
      vecs[10] = mk(10'h001, 1, 0, 0, 2'd2, 4'd3, 0);
      vecs[11] = mk(10'h001, 1, 0, 0, 2'd2, 4'd3, 1);
      vecs[12] = mk(10'h001, 1, 0, 0, 2'd2, 4'd3, 1);
      vecs[13] = mk(10'h001, 1, 0, 0, 2'd2, 4'd3, 1);
      vecs[14] = mk(10'h001, 1, 0, 0, 2'd2, 4'd3, 1);
      vecs[15] = mk(10'h000, 1, 0, 0, 2'd2, 4'd3, 1);
      vecs[16] = mk(10'h000, 1, 0, 1, 2'd3, 4'd3, 0);
      vecs[17] = mk(10'h002, 1, 0, 0, 2'd3, 4'd3, 0);
      vecs[18] = mk(10'h006, 1, 0, 0, 2'd3, 4'd3, 1);
      vecs[19] = mk(10'h006, 1, 0, 1, 2'd1, 4'd3, 1);
      vecs[20] = mk(10'h000, 1, 0, 0, 2'd1, 4'd3, 1);
      vecs[21] = mk(10'h000, 1, 0, 0, 2'd1, 4'd3, 0);
      vecs[22] = mk(10'h010, 1, 0, 0, 2'd1, 4'd3, 0);
      vecs[23] = mk(10'h010, 1, 0, 0, 2'd1, 4'd3, 1);
      vecs[24] = mk(10'h000, 1, 0, 0, 2'd1, 4'd3, 1);
      vecs[25] = mk(10'h000, 1, 1, 0, 2'd1, 4'd4, 0);
      vecs[26] = mk(10'h000, 1, 0, 0, 2'd1, 4'd4, 0);
      vecs[27] = mk(10'h080, 0, 0, 0, 2'd1, 4'd4, 0);
      vecs[28] = mk(10'h080, 0, 0, 0, 2'd1, 4'd4, 0);
      vecs[29] = mk(10'h080, 0, 0, 0, 2'd1, 4'd4, 0);
      vecs[30] = mk(10'h000, 1, 0, 0, 2'd1, 4'd4, 0);
      vecs[31] = mk(10'h020, 1, 0, 0, 2'd1, 4'd4, 0);
      vecs[32] = mk(10'h020, 1, 0, 0, 2'd1, 4'd4, 1);
      vecs[33] = mk(10'h020, 0, 0, 0, 2'd1, 4'd4, 1);
      vecs[34] = mk(10'h000, 1, 1, 0, 2'd1, 4'd5, 0);
      vecs[35] = mk(10'h004, 1, 0, 0, 2'd1, 4'd5, 0);
      vecs[36] = mk(10'h004, 1, 0, 0, 2'd1, 4'd5, 1);
      vecs[37] = mk(10'h008, 1, 0, 0, 2'd1, 4'd5, 1);
      vecs[38] = mk(10'h008, 1, 0, 1, 2'd1, 4'd5, 1);
      vecs[39] = mk(10'h000, 1, 0, 0, 2'd1, 4'd5, 1);
      vecs[40] = mk(10'h000, 1, 0, 0, 2'd1, 4'd5, 0);

      // Clock/reset
      rst_n   = 1'b1;
      enable  = 1'b1;
      data_in = '0;
      model_reset();
      @(negedge clk);
      do_reset(10'h000, "reset");

      // Directed vector table
      for (int i = 0; i < 41; i++) begin
         step(vecs[i].data, vecs[i].en);
         check($sformatf("vec%0d.digit_valid", i), int'(digit_valid), int'(vecs[i].valid));
         check($sformatf("vec%0d.err", i), int'(err), int'(vecs[i].err));
         check($sformatf("vec%0d.err_type", i), int'(err_type), int'(vecs[i].etype));
         check($sformatf("vec%0d.digit_out", i), int'(digit_out), int'(vecs[i].digit));
         check($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].busy));
      end

      // Reset on the second cycle of a pulse: pulse discarded, no digit.
      step(10'h040, 1);
      check_model("rst_mid.pre");
      do_reset(10'h040, "rst_mid");
      for (int i = 0; i < 4; i++) begin
         step(10'h000, 1);
         check_model("rst_mid.after");
      end

      // Tail of a pulse remaining after reset release decodes as too short.
      step(10'h100, 1);
      do_reset(10'h100, "rst_tail");
      step(10'h100, 1);
      check_model("rst_tail.t0");
      step(10'h000, 1);
      check_model("rst_tail.t1");
      step(10'h000, 1);
      check_model("rst_tail.t2");
      check("rst_tail.is_short", int'(err_type), 2);

      // Randomized pulses against the model
      for (int p = 0; p < 300; p++) begin
         int         code;
         int         len;
         int         gap;
         int         r;
         logic [9:0] d;
         logic       en;
         code = $urandom_range(0, 9);
         len  = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            d = 10'd1 << code;
            r = $urandom_range(0, 99);
            if (r < 4) d = d | (10'd1 << $urandom_range(0, 9));
            else if (r < 7) d = 10'd1 << $urandom_range(0, 9);
            en = ($urandom_range(0, 99) < 96);
            step(d, en);
            check_model("rand");
         end
         gap = $urandom_range(0, 2);
         for (int j = 0; j < gap; j++) begin
            step(10'h000, 1);
            check_model("rand.gap");
         end
         if ($urandom_range(0, 99) < 3) do_reset(10'd1 << $urandom_range(0, 9), "rand.rst");
      end
      for (int j = 0; j < 3; j++) begin
         step(10'h000, 1);
         check_model("drain");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pulse_narrow.md
PULSE_NARROW -- requirements
Module: pulse_narrow

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 2: minimum accepted pulse width in cycles.
REQ-002 SHALL have parameter MAX_WIDTH, default 3: maximum accepted pulse width in cycles; legal range MIN_WIDTH..6.
REQ-003 SHALL have port clk  input  1  clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  input  1  when low, data_in is treated as all-zero.
REQ-006 SHALL have port data_in  input  10  stretched one-hot digit line; bit n set means digit n.
REQ-007 SHALL have port digit_out  output  4  last successfully decoded digit, 0..9.
REQ-008 SHALL have port digit_valid  output  1  one-cycle pulse; digit_out is updated in the same cycle.
REQ-009 SHALL have port err  output  1  one-cycle pulse on a protocol violation.
REQ-010 SHALL have port err_type  output  2  qualified by err: 01 multi-hot/changed code, 10 too short, 11 too long.
REQ-011 SHALL have port busy  output  1  high when the FSM is not in IDLE.

Function
REQ-012 SHALL register the input as data_q <= enable ? data_in : 0; all decisions use data_q only.
REQ-013 SHALL implement FSM states IDLE, ACTIVE and DRAIN.
REQ-014 IDLE: when data_q is zero, SHALL stay in IDLE. When data_q is one-hot, SHALL capture the code as its bit index, set cnt=1 and go to ACTIVE. When data_q is multi-hot, SHALL pulse err with err_type=01 and go to DRAIN.
REQ-015 ACTIVE, data_q equal to the captured one-hot: SHALL increment cnt, saturating at MAX_WIDTH+1.
REQ-016 ACTIVE, data_q zero (end of pulse): SHALL go to IDLE. If MIN_WIDTH<=cnt<=MAX_WIDTH, SHALL pulse digit_valid and load digit_out with the code. If cnt<MIN_WIDTH, SHALL pulse err with type 10. If cnt>MAX_WIDTH, SHALL pulse err with type 11.
REQ-017 ACTIVE, data_q any other nonzero value: SHALL pulse err with type 01 and go to DRAIN; no digit is emitted.
REQ-018 DRAIN: SHALL stay in DRAIN until data_q is zero, then go to IDLE; no additional err is raised in DRAIN.
REQ-019 SHALL register all outputs. For data_in one-hot at edges k..k+W-1 and zero at edge k+W, digit_valid SHALL be high from edge k+W+1 to edge k+W+2.
REQ-020 SHALL never assert digit_valid and err in the same cycle.
REQ-021 SHALL hold digit_out between digit_valid pulses; err_type SHALL hold its last value.
REQ-022 enable falling mid-pulse: SHALL treat the pulse as ended (REQ-016), with the width check applied to the sampled count.
REQ-023 A pulse ending in the same cycle a new pulse starts, i.e. with no zero gap, SHALL be treated as a changed code (REQ-017).
REQ-024 SHALL require a minimum of one zero cycle between accepted pulses; throughput SHALL be one digit per W+1 cycles.

Reset
REQ-025 On rst_n low, SHALL asynchronously clear data_q, cnt, code, digit_out, err_type, digit_valid, err and busy to 0, and set the state to IDLE.
REQ-026 Reset mid-pulse SHALL discard the pulse. After release, a remaining tail of that pulse SHALL be decoded as a new pulse, normally rejected as too short.

Structure
REQ-027 SHALL place the state enum, the err_type codes and the default width constants in shared package pulse_narrow_pkg.
REQ-028 SHALL use a combinational sub-module onehot_index, which maps 10 bits to a 4-bit index plus is_zero, is_onehot and is_multi flags.
REQ-029 cnt SHALL be 3 bits wide.

Verification
REQ-030 data_in=10'h008 for 3 cycles, then 0 -> one digit_valid with digit_out=3, exactly 2 edges after the line clears; err stays 0.
REQ-031 data_in=10'h200 for 1 cycle -> err=1, err_type=10; digit_out unchanged.
REQ-032 data_in=10'h001 for 5 cycles -> err=1, err_type=11.
REQ-033 data_in=10'h002 for 1 cycle, then 10'h006 for 2 cycles, then 0 -> single err with type 01; busy until the line is zero; then 10'h010 for 2 cycles -> digit_out=4.
REQ-034 data_in=10'h040 for 2 cycles, with rst_n pulsed low on the 2nd cycle -> all outputs 0 and busy=0 while rst_n is low; no digit_valid.
REQ-035 enable=0 with data_in=10'h080 for 3 cycles -> no digit_valid, no err; busy stays 0.
